// File: rtl/isi_frame_transmitter_if.sv
// Stream-pixel handshake between a pixel source and the ISI frame transmitter.
//   pix_valid_i : source has a pixel on pix_i
//   pix_i       : stream pixel
//   pix_ready_o : transmitter consumes pix_i this cycle (when valid)
// Port names carry the transmitter's point of view (i = into it, o = out of it).
interface isi_frame_transmitter_if #(
  parameter int PIX_WIDTH = 8
);
  logic                 pix_valid_i;
  logic [PIX_WIDTH-1:0] pix_i;
  logic                 pix_ready_o;

  modport master (output pix_valid_i, output pix_i, input  pix_ready_o);
  modport slave  (input  pix_valid_i, input  pix_i, output pix_ready_o);
endinterface

// File: rtl/isi_frame_transmitter.sv
// ISI camera timing generator: emits pixel_data/hsync/vsync on pixclk_i from
// either an internal pixel stream or a (col+row) test pattern.
//   pixclk_i      : sole clock
//   reset         : synchronous, active high
//   enable_i      : level; frames run back-to-back while high
//   pattern_i     : 1 = test pattern, 0 = stream; latched at frame start
//   s_pix         : stream handshake (valid/pixel in, ready out)
//   pixel_data_o  : ISI pixel bus, zero outside active pixels
//   hsync_o       : high for the active pixels of a line
//   vsync_o       : frame sync pulse, falls before the first line
//   frame_done_o  : one-cycle pulse as the frame's trailing blank ends
//   underflow_o   : sticky, stream had no pixel when one was needed
//   busy_o        : low only when idle
//
// All sync/data outputs are registered from the current state, so they
// trail the state machine by one cycle. pix_ready_o is a decode of the state
// register, which puts an accepted pixel on the bus in the next cycle with
// hsync_o high.
module isi_frame_transmitter #(
  parameter int PIX_WIDTH     = 8,
  parameter int ACTIVE_WIDTH  = 320,
  parameter int ACTIVE_HEIGHT = 240,
  parameter int H_BLANK       = 16,
  parameter int VSYNC_CYCLES  = 8,
  parameter int V_BACK        = 32,
  parameter int V_FRONT       = 32
) (
  input  logic                   pixclk_i,
  input  logic                   reset,
  input  logic                   enable_i,
  input  logic                   pattern_i,
  isi_frame_transmitter_if.slave s_pix,
  output logic [PIX_WIDTH-1:0]   pixel_data_o,
  output logic                   hsync_o,
  output logic                   vsync_o,
  output logic                   frame_done_o,
  output logic                   underflow_o,
  output logic                   busy_o
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_VSYNC  = 3'd1;
  localparam logic [2:0] S_VBACK  = 3'd2;
  localparam logic [2:0] S_LINE   = 3'd3;
  localparam logic [2:0] S_HBLANK = 3'd4;
  localparam logic [2:0] S_VFRONT = 3'd5;

  localparam logic [15:0] VS_LAST  = 16'(VSYNC_CYCLES - 1);
  localparam logic [15:0] VB_LAST  = 16'(V_BACK - 1);
  localparam logic [15:0] COL_LAST = 16'(ACTIVE_WIDTH - 1);
  localparam logic [15:0] ROW_LAST = 16'(ACTIVE_HEIGHT - 1);
  localparam logic [15:0] HB_LAST  = 16'(H_BLANK - 1);
  localparam logic [15:0] VF_LAST  = 16'((V_FRONT > 0) ? V_FRONT - 1 : 0);

  logic [2:0]           r_state;
  logic [15:0]          r_cnt;      // cycle count inside the blanking/sync states
  logic [15:0]          r_col;
  logic [15:0]          r_row;
  logic                 r_pattern;
  logic                 r_hsync;
  logic                 r_vsync;
  logic                 r_frame_done;
  logic                 r_underflow;
  logic                 r_busy;
  logic [PIX_WIDTH-1:0] r_pix;

  logic [2:0]           w_state_nxt;
  logic [15:0]          w_cnt_nxt;
  logic [15:0]          w_col_nxt;
  logic [15:0]          w_row_nxt;
  logic                 w_frame_end;
  logic                 w_start;
  logic                 w_line;
  logic [15:0]          w_pat_sum;
  logic [PIX_WIDTH-1:0] w_pat_pix;

  assign w_line    = (r_state == S_LINE);
  assign w_pat_sum = r_col + r_row;
  assign w_pat_pix = PIX_WIDTH'(w_pat_sum);

  assign s_pix.pix_ready_o = w_line & ~r_pattern;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_col_nxt   = r_col;
    w_row_nxt   = r_row;
    w_frame_end = 1'b0;
    w_start     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (enable_i) begin
          w_state_nxt = S_VSYNC;
          w_cnt_nxt   = '0;
          w_col_nxt   = '0;
          w_row_nxt   = '0;
          w_start     = 1'b1;
        end
      end
      S_VSYNC: begin
        if (r_cnt == VS_LAST) begin
          w_state_nxt = S_VBACK;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 16'd1;
        end
      end
      S_VBACK: begin
        if (r_cnt == VB_LAST) begin
          w_state_nxt = S_LINE;
          w_cnt_nxt   = '0;
          w_col_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 16'd1;
        end
      end
      S_LINE: begin
        if (r_col == COL_LAST) begin
          w_state_nxt = S_HBLANK;
          w_cnt_nxt   = '0;
        end else begin
          w_col_nxt = r_col + 16'd1;
        end
      end
      S_HBLANK: begin
        if (r_cnt != HB_LAST) begin
          w_cnt_nxt = r_cnt + 16'd1;
        end else if (r_row != ROW_LAST) begin
          w_state_nxt = S_LINE;
          w_cnt_nxt   = '0;
          w_col_nxt   = '0;
          w_row_nxt   = r_row + 16'd1;
        end else if (V_FRONT == 0) begin
          // no front porch: the frame ends straight out of the last blank
          w_frame_end = 1'b1;
        end else begin
          w_state_nxt = S_VFRONT;
          w_cnt_nxt   = '0;
        end
      end
      S_VFRONT: begin
        if (r_cnt == VF_LAST) w_frame_end = 1'b1;
        else                  w_cnt_nxt   = r_cnt + 16'd1;
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // enable_i is only looked at between frames, so dropping it mid-frame
    // lets the current frame finish cleanly
    if (w_frame_end) begin
      w_cnt_nxt = '0;
      w_col_nxt = '0;
      w_row_nxt = '0;
      if (enable_i) begin
        w_state_nxt = S_VSYNC;
        w_start     = 1'b1;
      end else begin
        w_state_nxt = S_IDLE;
      end
    end
  end

  always_ff @(posedge pixclk_i) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_col        <= '0;
      r_row        <= '0;
      r_pattern    <= 1'b0;
      r_hsync      <= 1'b0;
      r_vsync      <= 1'b0;
      r_frame_done <= 1'b0;
      r_underflow  <= 1'b0;
      r_busy       <= 1'b0;
      r_pix        <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_col        <= w_col_nxt;
      r_row        <= w_row_nxt;
      if (w_start) r_pattern <= pattern_i;
      r_vsync      <= (r_state == S_VSYNC);
      r_hsync      <= w_line;
      r_frame_done <= w_frame_end;
      r_busy       <= (w_state_nxt != S_IDLE);
      // a missing stream pixel still burns its slot; the line is never stretched
      if (w_line) r_pix <= r_pattern ? w_pat_pix : (s_pix.pix_valid_i ? s_pix.pix_i : '0);
      else        r_pix <= '0;
      if (w_line && !r_pattern && !s_pix.pix_valid_i) r_underflow <= 1'b1;
    end
  end

  assign pixel_data_o = r_pix;
  assign hsync_o      = r_hsync;
  assign vsync_o      = r_vsync;
  assign frame_done_o = r_frame_done;
  assign underflow_o  = r_underflow;
  assign busy_o       = r_busy;

endmodule
